// File: rtl/fig42_sweep_if.sv
// Handshake and observation bundle between the sweep controller and the
// circuit under test / requesting agent.
interface fig42_sweep_if;
  logic        start;
  logic        abort;
  logic [3:0]  abcd;
  logic        f1;
  logic        f2;
  logic        busy;
  logic        done;
  logic [15:0] table_f1;
  logic [15:0] table_f2;
  logic        result_valid;
  logic        pass;
  logic        fail_valid;
  logic [3:0]  fail_idx;

  // Requester side: drives control, provides circuit outputs, observes results.
  modport master (
    output start, abort, f1, f2,
    input  abcd, busy, done, table_f1, table_f2,
    input  result_valid, pass, fail_valid, fail_idx
  );

  // Controller side.
  modport slave (
    input  start, abort, f1, f2,
    output abcd, busy, done, table_f1, table_f2,
    output result_valid, pass, fail_valid, fail_idx
  );
endinterface

// File: rtl/fig42_sweep_ctrl.sv
// Exhaustive sweep sequencer for the 4-in/2-out gate circuit: applies vectors
// 0..15, captures F1/F2 truth tables and compares them with golden tables.
module fig42_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [15:0] EXP_F1        = 16'hC0AA,
  parameter logic [15:0] EXP_F2        = 16'hC055
) (
  input  logic         clk,
  input  logic         rst,
  fig42_sweep_if.slave bus
);

  localparam int unsigned IDX_W    = 4;
  localparam int unsigned TAB_W    = 16;
  localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TAB_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_SAMPLE,
    S_DONE
  } state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   abcd_q;
  logic [IDX_W-1:0]   fail_idx_q;
  logic [TAB_W-1:0]   table_f1_q;
  logic [TAB_W-1:0]   table_f2_q;
  logic               busy_q;
  logic               done_q;
  logic               result_valid_q;
  logic               pass_q;
  logic               fail_valid_q;

  logic               mismatch_c;
  logic               fail_valid_d;
  logic [IDX_W-1:0]   idx_d;

  // Verdict for the vector currently being sampled; folded into pass on the last one.
  assign mismatch_c   = (bus.f1 != EXP_F1[idx_q]) || (bus.f2 != EXP_F2[idx_q]);
  assign fail_valid_d = fail_valid_q | mismatch_c;
  assign idx_d        = idx_q + IDX_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      cnt_q          <= '0;
      abcd_q         <= '0;
      fail_idx_q     <= '0;
      table_f1_q     <= '0;
      table_f2_q     <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      result_valid_q <= 1'b0;
      pass_q         <= 1'b0;
      fail_valid_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.start && !bus.abort) begin
            state_q        <= S_APPLY;
            idx_q          <= '0;
            cnt_q          <= '0;
            abcd_q         <= '0;
            table_f1_q     <= '0;
            table_f2_q     <= '0;
            result_valid_q <= 1'b0;
            pass_q         <= 1'b0;
            fail_valid_q   <= 1'b0;
            fail_idx_q     <= '0;
            busy_q         <= 1'b1;
          end
        end

        S_APPLY: begin
          if (bus.abort) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= S_SAMPLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + IDX_W'(1);
          end
        end

        S_SAMPLE: begin
          if (bus.abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            table_f1_q[idx_q] <= bus.f1;
            table_f2_q[idx_q] <= bus.f2;
            if (mismatch_c && !fail_valid_q) begin
              fail_valid_q <= 1'b1;
              fail_idx_q   <= idx_q;
            end
            // Last vector: publish the verdict together with the done pulse.
            if (idx_q == IDX_LAST) begin
              state_q        <= S_DONE;
              busy_q         <= 1'b0;
              done_q         <= 1'b1;
              result_valid_q <= 1'b1;
              pass_q         <= ~fail_valid_d;
            end else begin
              state_q <= S_APPLY;
              idx_q   <= idx_d;
              abcd_q  <= idx_d;
            end
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.abcd         = abcd_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.table_f1     = table_f1_q;
  assign bus.table_f2     = table_f2_q;
  assign bus.result_valid = result_valid_q;
  assign bus.pass         = pass_q;
  assign bus.fail_valid   = fail_valid_q;
  assign bus.fail_idx     = fail_idx_q;

endmodule

// File: tb/tb_fig42_sweep_ctrl.sv
// Directed bench for the sweep controller: golden, faulty and aborted sweeps
// on the default instance, plus a single-cycle-settle instance.
module tb_fig42_sweep_ctrl;

  localparam logic [15:0] GOLD_F1 = 16'hC0AA;
  localparam logic [15:0] GOLD_F2 = 16'hC055;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   fault_mode;

  fig42_sweep_if bus ();
  fig42_sweep_if bus1 ();

  fig42_sweep_ctrl #(.SETTLE_CYCLES(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  fig42_sweep_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Circuit model: golden gates, optionally with F1 stuck at 0 or F2 flipped at ABCD=14.
  always_comb begin
    bus.f1  = GOLD_F1[bus.abcd] & (fault_mode != 1);
    bus.f2  = GOLD_F2[bus.abcd] ^ ((fault_mode == 2) && (bus.abcd == 4'd14));
    bus1.f1 = GOLD_F1[bus1.abcd];
    bus1.f2 = GOLD_F2[bus1.abcd];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Start edge is the posedge between the two negedges; returns in cycle 1.
  task automatic start_sweep();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
  endtask

  // Runs from cycle 1 until done (bounded), checking abcd/busy each cycle.
  task automatic sweep(input int restart_at, output int cyc, output int step_err);
    cyc = 1;
    step_err = 0;
    while (cyc < 200 && !bus.done) begin
      if (bus.abcd != 4'((cyc - 1) / 3) || !bus.busy) step_err++;
      bus.start = (cyc == restart_at);
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
  endtask

  task automatic watch_idle(input int n, output int done_cnt, output int busy_cnt);
    done_cnt = 0;
    busy_cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
      if (bus.busy) busy_cnt++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 500000");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, err, dcnt, bcnt;
    n_tests    = 0;
    n_fail     = 0;
    fault_mode = 0;
    bus.start  = 1'b0;
    bus.abort  = 1'b0;
    bus1.start = 1'b0;
    bus1.abort = 1'b0;
    rst        = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_abcd",   32'(bus.abcd), 32'd0);
    check("rst_busy",   32'(bus.busy), 32'd0);
    check("rst_done",   32'(bus.done), 32'd0);
    check("rst_tabs",   32'({bus.table_f1, bus.table_f2}), 32'd0);
    check("rst_flags",  32'({bus.result_valid, bus.pass, bus.fail_valid, bus.fail_idx}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Golden sweep with a stray start at cycle 20 and abort during DONE
    start_sweep();
    check("g_busy_c1", 32'(bus.busy), 32'd1);
    sweep(20, cyc, err);
    check("g_done_cyc", 32'(cyc), 32'd49);
    check("g_steps",    32'(err), 32'd0);
    check("g_busy_done", 32'(bus.busy), 32'd0);
    check("g_tf1",  32'(bus.table_f1), 32'hC0AA);
    check("g_tf2",  32'(bus.table_f2), 32'hC055);
    check("g_flags", 32'({bus.result_valid, bus.pass, bus.fail_valid}), 32'b110);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("g_done_pulse", 32'(bus.done), 32'd0);
    watch_idle(5, dcnt, bcnt);
    check("g_hold", 32'({bus.result_valid, bus.pass, bus.fail_valid}), 32'b110);
    check("g_idle_busy", 32'(bcnt), 32'd0);

    // F1 stuck at 0
    fault_mode = 1;
    start_sweep();
    check("s_cleared", 32'({bus.result_valid, bus.pass, bus.fail_valid, bus.table_f1}), 32'd0);
    sweep(0, cyc, err);
    check("s_done_cyc", 32'(cyc), 32'd49);
    check("s_tf1", 32'(bus.table_f1), 32'h0000);
    check("s_tf2", 32'(bus.table_f2), 32'hC055);
    check("s_flags", 32'({bus.result_valid, bus.pass, bus.fail_valid}), 32'b101);
    check("s_fidx", 32'(bus.fail_idx), 32'd1);

    // F2 flipped only at ABCD=14
    fault_mode = 2;
    start_sweep();
    sweep(0, cyc, err);
    check("i_done_cyc", 32'(cyc), 32'd49);
    check("i_tf1", 32'(bus.table_f1), 32'hC0AA);
    check("i_tf2", 32'(bus.table_f2), 32'h8055);
    check("i_flags", 32'({bus.result_valid, bus.pass, bus.fail_valid}), 32'b101);
    check("i_fidx", 32'(bus.fail_idx), 32'd14);
    fault_mode = 0;

    // Abort in cycle 10 (vector 3 applied, vectors 0..2 captured)
    start_sweep();
    repeat (9) @(negedge clk);
    check("a_pre_abcd", 32'(bus.abcd), 32'd3);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("a_busy", 32'(bus.busy), 32'd0);
    check("a_abcd", 32'(bus.abcd), 32'd3);
    check("a_part", 32'({bus.table_f1, bus.table_f2}), 32'h0002_0005);
    watch_idle(60, dcnt, bcnt);
    check("a_no_done", 32'(dcnt), 32'd0);
    check("a_rv", 32'(bus.result_valid), 32'd0);
    check("a_frozen", 32'(bus.abcd), 32'd3);

    // Abort and start together in IDLE: abort wins
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("as_busy", 32'(bus.busy), 32'd0);
    check("as_abcd", 32'(bus.abcd), 32'd3);

    // Clean sweep after abort
    start_sweep();
    sweep(0, cyc, err);
    check("r_done_cyc", 32'(cyc), 32'd49);
    check("r_steps", 32'(err), 32'd0);
    check("r_pass", 32'({bus.result_valid, bus.pass, bus.fail_valid}), 32'b110);

    // Reset asserted mid-cycle at cycle 30
    start_sweep();
    repeat (29) @(negedge clk);
    check("x_pre_abcd", 32'(bus.abcd), 32'd9);
    #2 rst = 1'b1;
    #1;
    check("x_abcd", 32'(bus.abcd), 32'd0);
    check("x_busy", 32'(bus.busy), 32'd0);
    check("x_tabs", 32'({bus.table_f1, bus.table_f2}), 32'd0);
    check("x_flags", 32'({bus.done, bus.result_valid, bus.pass, bus.fail_valid, bus.fail_idx}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    watch_idle(60, dcnt, bcnt);
    check("x_no_done", 32'(dcnt), 32'd0);
    check("x_idle", 32'(bcnt), 32'd0);

    // Single-cycle settle instance
    @(negedge clk); bus1.start = 1'b1;
    @(negedge clk); bus1.start = 1'b0;
    cyc = 1;
    while (cyc < 200 && !bus1.done) begin
      @(negedge clk);
      cyc++;
    end
    check("k_done_cyc", 32'(cyc), 32'd33);
    check("k_tabs", 32'({bus1.table_f1, bus1.table_f2}), 32'hC0AA_C055);
    check("k_flags", 32'({bus1.result_valid, bus1.pass, bus1.fail_valid}), 32'b110);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
